rvfi_trace_fifo: RTL and testbench

- Downstream consumer of the otter_mcu RVFI retirement port.
- Captures one compact trace record per retired instruction into a DEPTH-entry FIFO.
- Serializes each record as four 32-bit beats on a valid/ready stream for a trace sink (UART bridge, logic analyzer, simulation monitor).
- Counts records dropped on overflow and flags the first record after any loss.

---
 rtl/rvfi_trace_fifo.sv | 148 ++++++++++++++
 tb/tb_rvfi_trace_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_trace_fifo.sv
// rvfi_trace_fifo: RVFI retirement trace capture FIFO.
// Emits one 4-beat record per retired instruction, counts overflow drops.
module rvfi_trace_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SYNC_WORD = 8'hA5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic                     i_clr,
  input  logic                     i_rvfi_valid,
  input  logic [63:0]              i_rvfi_order,
  input  logic [31:0]              i_rvfi_insn,
  input  logic [31:0]              i_rvfi_pc_rdata,
  input  logic [31:0]              i_rvfi_pc_wdata,
  input  logic                     i_rvfi_trap,
  input  logic                     i_rvfi_intr,
  output logic                     o_tvalid,
  output logic [31:0]              o_tdata,
  output logic                     o_tlast,
  input  logic                     i_tready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [15:0]              o_drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  logic [31:0] pc_r_mem [DEPTH];
  logic [31:0] insn_mem [DEPTH];
  logic [31:0] pc_w_mem [DEPTH];
  logic [18:0] meta_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic [1:0]    beat;
  logic          lost;
  logic [15:0]   drop_cnt;

  logic fire;
  logic full;
  logic push;
  logic drop;
  logic accept;
  logic pop;
  logic tvalid;
  logic [18:0] head_meta;
  logic [31:0] head_word;
  logic order_unused;

  assign order_unused = ^i_rvfi_order[63:16];

  // Push/drop/pop qualification; full is sampled before any pop.
  always_comb begin
    fire   = i_rvfi_valid && i_en && !i_clr;
    full   = (count == FULL_CNT);
    push   = fire && !full;
    drop   = fire && full;
    tvalid = (count != '0);
    accept = tvalid && i_tready && !i_clr;
    pop    = accept && (beat == 2'd3);
  end

  // Record storage; the header is rebuilt from the meta field on read.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_r_mem[wr_ptr] <= i_rvfi_pc_rdata;
      insn_mem[wr_ptr] <= i_rvfi_insn;
      pc_w_mem[wr_ptr] <= i_rvfi_pc_wdata;
      meta_mem[wr_ptr] <= {lost, i_rvfi_trap,
                           i_rvfi_intr,
                           i_rvfi_order[15:0]};
    end
  end

  // Pointers, occupancy and beat index; clear wins over everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= 2'd0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      beat   <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (accept) begin
        beat <= beat + 2'd1;
      end
      if (push && !pop) begin
        count <= count + LW'(1);
      end else if (pop && !push) begin
        count <= count - LW'(1);
      end
    end
  end

  // Drop counter saturates; lost marks the next pushed record.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt <= 16'h0000;
      lost     <= 1'b0;
    end else if (i_clr) begin
      drop_cnt <= 16'h0000;
      lost     <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'h0001;
      end
      lost <= 1'b1;
    end else if (push) begin
      lost <= 1'b0;
    end
  end

  // Head word select by beat index; idle output is forced to zero.
  always_comb begin
    head_meta = meta_mem[rd_ptr];
    head_word = 32'h0;
    case (beat)
      2'd0: head_word = {SYNC_WORD, 5'b0, head_meta};
      2'd1: head_word = pc_r_mem[rd_ptr];
      2'd2: head_word = insn_mem[rd_ptr];
      2'd3: head_word = pc_w_mem[rd_ptr];
      default: head_word = 32'h0;
    endcase
  end

  // Output drive from registered state only.
  always_comb begin
    o_tvalid   = tvalid;
    o_tdata    = tvalid ? head_word : 32'h0;
    o_tlast    = tvalid && (beat == 2'd3);
    o_level    = count;
    o_drop_cnt = drop_cnt;
  end

endmodule

// File: tb/tb_rvfi_trace_fifo.sv
// tb_rvfi_trace_fifo: directed bench for rvfi_trace_fifo.
// Beat scoreboard fed on retire, compared at every negedge.
module tb_rvfi_trace_fifo;

  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic valid = 1'b0;
  logic [63:0] order = 64'h0;
  logic [31:0] insn = 32'h0;
  logic [31:0] pc_r = 32'h0;
  logic [31:0] pc_w = 32'h0;
  logic trap = 1'b0;
  logic intr = 1'b0;
  logic tready = 1'b0;

  logic o_tvalid;
  logic [31:0] o_tdata;
  logic o_tlast;
  logic [LW-1:0] o_level;
  logic [15:0] o_drop_cnt;

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q[$];
  int m_count = 0;
  logic [1:0] m_beat = 2'd0;
  logic [15:0] m_drop = 16'h0;
  logic m_lost = 1'b0;
  bit m_full;
  bit m_fire;
  bit m_acc;
  bit m_pop;
  logic [31:0] m_hdr;

  rvfi_trace_fifo #(
    .DEPTH(DEPTH),
    .SYNC_WORD(8'hA5)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_en(en),
    .i_clr(clr),
    .i_rvfi_valid(valid),
    .i_rvfi_order(order),
    .i_rvfi_insn(insn),
    .i_rvfi_pc_rdata(pc_r),
    .i_rvfi_pc_wdata(pc_w),
    .i_rvfi_trap(trap),
    .i_rvfi_intr(intr),
    .o_tvalid(o_tvalid),
    .o_tdata(o_tdata),
    .o_tlast(o_tlast),
    .i_tready(tready),
    .o_level(o_level),
    .o_drop_cnt(o_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference model: advances on each clock edge or async reset.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || clr) begin
      exp_q.delete();
      m_count = 0;
      m_beat = 2'd0;
      m_drop = 16'h0;
      m_lost = 1'b0;
    end else begin
      m_full = (m_count == DEPTH);
      m_fire = valid && en;
      m_acc = (m_count != 0) && tready;
      m_pop = m_acc && (m_beat == 2'd3);
      if (m_acc) begin
        void'(exp_q.pop_front());
        m_beat = m_beat + 2'd1;
      end
      if (m_fire && m_full) begin
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
        m_lost = 1'b1;
      end else if (m_fire) begin
        m_hdr = {8'hA5, 5'b0, m_lost, trap, intr,
                 order[15:0]};
        exp_q.push_back({1'b0, m_hdr});
        exp_q.push_back({1'b0, pc_r});
        exp_q.push_back({1'b0, insn});
        exp_q.push_back({1'b1, pc_w});
        m_lost = 1'b0;
        m_count++;
      end
      if (m_pop) m_count--;
    end
  end

  // Output monitor, sampled mid-cycle.
  always begin
    @(negedge clk);
    if (rst_n) begin
      check("tvalid", 32'(o_tvalid), 32'(m_count != 0));
      check("level", 32'(o_level), 32'(m_count));
      check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop));
      if (m_count != 0) begin
        check("tdata", o_tdata, exp_q[0][31:0]);
        check("tlast", 32'(o_tlast), 32'(exp_q[0][32]));
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic retire(input logic [15:0] ord,
                        input logic [31:0] pr,
                        input logic [31:0] in,
                        input logic [31:0] pw,
                        input logic tr);
    valid = 1'b1;
    order = {48'hC0DE_0000_1234, ord};
    pc_r = pr;
    insn = in;
    pc_w = pw;
    trap = tr;
    intr = 1'b0;
    step(1);
    valid = 1'b0;
    trap = 1'b0;
  endtask

  task automatic drain(input bit bp);
    logic [3:0] pat;
    pat = 4'b1001;
    for (int i = 0; i < 200 && m_count != 0; i++) begin
      tready = bp ? pat[i % 4] : 1'b1;
      step(1);
    end
    tready = 1'b0;
    @(negedge clk);
    check("drain_level", 32'(o_level), 32'd0);
  endtask

  logic [31:0] single_beats [4];

  initial begin
    single_beats[0] = 32'hA500_0005;
    single_beats[1] = 32'h0000_0100;
    single_beats[2] = 32'h0050_0093;
    single_beats[3] = 32'h0000_0104;

    #12;
    check("rst_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_tdata", o_tdata, 32'd0);
    check("rst_tlast", 32'(o_tlast), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_drop", 32'(o_drop_cnt), 32'd0);
    rst_n = 1'b1;
    en = 1'b1;
    step(2);

    tready = 1'b1;
    retire(16'd5, 32'h100, 32'h0050_0093, 32'h104, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("single_data", o_tdata, single_beats[b]);
      check("single_last", 32'(o_tlast), 32'(b == 3));
      step(1);
    end
    @(negedge clk);
    check("single_level", 32'(o_level), 32'd0);
    check("single_tvalid", 32'(o_tvalid), 32'd0);

    tready = 1'b0;
    retire(16'h0001, 32'h200, 32'h1111_1111, 32'h204, 1'b0);
    retire(16'h0002, 32'h204, 32'h2222_2222, 32'h208, 1'b0);
    @(negedge clk);
    check("bp_level", 32'(o_level), 32'd2);
    drain(1'b1);

    for (int i = 0; i < DEPTH + 3; i++) begin
      retire(16'(16'h10 + i), 32'(32'h1000 + 4 * i),
             32'(32'hAB00 + i), 32'(32'h1004 + 4 * i), 1'b0);
    end
    @(negedge clk);
    check("ovf_level", 32'(o_level), 32'(DEPTH));
    check("ovf_drop", 32'(o_drop_cnt), 32'd3);
    tready = 1'b1;
    step(8);
    tready = 1'b0;
    retire(16'h0020, 32'h3000, 32'h0000_0073, 32'h3004, 1'b1);
    retire(16'h0021, 32'h3004, 32'h0000_0013, 32'h3008, 1'b0);
    tready = 1'b1;
    step(8);
    @(negedge clk);
    check("lost_hdr", o_tdata, 32'hA506_0020);
    step(4);
    @(negedge clk);
    check("next_hdr", o_tdata, 32'hA500_0021);
    drain(1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      retire(16'(16'h30 + i), 32'(32'h4000 + 4 * i),
             32'(32'hCD00 + i), 32'(32'h4004 + 4 * i), 1'b0);
    end
    tready = 1'b1;
    step(3);
    retire(16'h0034, 32'h5000, 32'h0000_0013, 32'h5004, 1'b0);
    @(negedge clk);
    check("pp_level", 32'(o_level), 32'(DEPTH - 1));
    check("pp_drop", 32'(o_drop_cnt), 32'd4);
    retire(16'h0035, 32'h5100, 32'h0000_0013, 32'h5104, 1'b0);
    drain(1'b0);

    en = 1'b0;
    retire(16'h0040, 32'h6000, 32'h0000_0013, 32'h6004, 1'b0);
    retire(16'h0041, 32'h6004, 32'h0000_0013, 32'h6008, 1'b0);
    @(negedge clk);
    check("en_level", 32'(o_level), 32'd0);
    check("en_drop", 32'(o_drop_cnt), 32'd4);
    en = 1'b1;
    retire(16'h0042, 32'h6100, 32'h0000_0013, 32'h6104, 1'b0);
    tready = 1'b1;
    step(2);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    @(negedge clk);
    check("clr_tvalid", 32'(o_tvalid), 32'd0);
    check("clr_level", 32'(o_level), 32'd0);
    check("clr_drop", 32'(o_drop_cnt), 32'd0);

    retire(16'h0050, 32'h7000, 32'h0000_0013, 32'h7004, 1'b0);
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 32'(o_tvalid), 32'd0);
    check("arst_tdata", o_tdata, 32'd0);
    check("arst_tlast", 32'(o_tlast), 32'd0);
    check("arst_level", 32'(o_level), 32'd0);
    check("arst_drop", 32'(o_drop_cnt), 32'd0);
    #2;
    rst_n = 1'b1;
    step(1);
    retire(16'h0055, 32'h8000, 32'h0000_0013, 32'h8004, 1'b0);
    @(negedge clk);
    check("arst_hdr", o_tdata, 32'hA500_0055);
    drain(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
